// File: rtl/store_buffer.sv
// store_buffer
//   Write-side buffer between the processor's memory stage and data memory.
//   Stores are queued in a circular FIFO and drained to memory over a
//   valid/ready channel; loads that hit a pending store get the youngest
//   matching data, so the processor always sees coherent read data.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   cpu_memwrite      store request (held by the processor while cpu_stall=1)
//   cpu_memread       load request
//   cpu_addr          byte address for loads and stores
//   cpu_wdata         store data
//   cpu_readdata      load data (forwarded or from memory)
//   cpu_stall         store not accepted this cycle
//   mem_wvalid/ready  write channel handshake to memory
//   mem_waddr/wdata   head entry address/data
//   mem_raddr         load address to memory (mirrors cpu_addr)
//   mem_rdata         combinational memory read data
//   count, empty      occupancy
//
// Write channel handshake: mem_wvalid is high whenever the buffer holds an
// entry; mem_waddr/mem_wdata show the head entry and only change after a
// transfer. A transfer (deq) happens on any rising edge where mem_wvalid and
// mem_wready are both high; mem_wvalid never depends on mem_wready.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_memwrite,
    input  logic                       cpu_memread,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_wdata,
    output logic [DW-1:0]              cpu_readdata,
    output logic                       cpu_stall,
    output logic                       mem_wvalid,
    input  logic                       mem_wready,
    output logic [AW-1:0]              mem_waddr,
    output logic [DW-1:0]              mem_wdata,
    output logic [AW-1:0]              mem_raddr,
    input  logic [DW-1:0]              mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic          full;
    logic          deq;
    logic          enq;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] idx;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign mem_wvalid = !empty;
    assign mem_waddr  = addr_q[head];
    assign mem_wdata  = data_q[head];
    assign mem_raddr  = cpu_addr;

    // A full buffer can still take a store in the cycle the head drains.
    assign deq       = mem_wvalid & mem_wready;
    assign enq       = cpu_memwrite & (!full | deq);
    assign cpu_stall = cpu_memwrite & full & !deq;

    // Pointers and occupancy. Entries beyond count are invalid, so clearing
    // count on reset discards every pending store, including one that is
    // mid-handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (deq) head <= head + PW'(1);
            if (enq) tail <= tail + PW'(1);
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload needs no reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (reset && enq) begin
            addr_q[tail] <= cpu_addr;
            data_q[tail] <= cpu_wdata;
        end
    end

    // Walk entries oldest to youngest so the last match (closest to tail)
    // wins. The head entry counts even if it is draining this cycle.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        cpu_readdata = mem_rdata;
        if (cpu_memread && cpu_memwrite) begin
            cpu_readdata = '0;
        end else if (cpu_memread && fwd_hit) begin
            cpu_readdata = fwd_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Drives store_buffer with a vector table, corner-case sequences and
//   random traffic. A queue of pending {addr, data} entries serves as the
//   reference; every cycle the DUT outputs are compared with it.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_readdata;
    logic        cpu_stall;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [2:0]  count;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memwrite (cpu_memwrite),
        .cpu_memread  (cpu_memread),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_readdata (cpu_readdata),
        .cpu_stall    (cpu_stall),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .count        (count),
        .empty        (empty)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];      // pending stores {addr, data}, oldest first
    logic [31:0] drained[$];    // addresses seen leaving on mem_w*
    int          checks = 0;
    int          errors = 0;

    // samples taken at the negedge of the last cycle
    logic [31:0] s_rdata, s_waddr, s_wdata;
    logic        s_stall, s_wvalid, s_empty;
    logic [2:0]  s_count;
    logic        last_enq;

    // write-channel stability tracking
    logic        prev_hold = 1'b0;
    logic [31:0] prev_waddr, prev_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic we, input logic re,
                                               input logic [31:0] a, input logic [31:0] rd);
        if (re && we) return 32'h0;
        if (!re) return rd;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k][63:34] == a[31:2]) return exp_q[k][31:0];
        end
        return rd;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    // Called just after a rising edge; inputs are applied, outputs checked
    // at the falling edge, the model advanced, then the next edge awaited.
    task automatic cycle(input logic rst, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic wr, input logic [31:0] rd);
        int  n;
        logic m_deq, m_enq, m_stall;
        reset        = rst;
        cpu_memwrite = we;
        cpu_memread  = re;
        cpu_addr     = a;
        cpu_wdata    = d;
        mem_wready   = wr;
        mem_rdata    = rd;
        @(negedge clk);
        n       = exp_q.size();
        m_deq   = (n != 0) && wr;
        m_enq   = we && ((n < DEPTH) || m_deq);
        m_stall = we && (n == DEPTH) && !m_deq;

        s_rdata  = cpu_readdata;
        s_stall  = cpu_stall;
        s_wvalid = mem_wvalid;
        s_waddr  = mem_waddr;
        s_wdata  = mem_wdata;
        s_count  = count;
        s_empty  = empty;

        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("wvalid", 64'(mem_wvalid), 64'(n != 0));
        if (n != 0) begin
            chk("waddr", 64'(mem_waddr), 64'(exp_q[0][63:32]));
            chk("wdata", 64'(mem_wdata), 64'(exp_q[0][31:0]));
        end
        if (prev_hold) begin
            chk("waddr_stable", 64'(mem_waddr), 64'(prev_waddr));
            chk("wdata_stable", 64'(mem_wdata), 64'(prev_wdata));
        end
        chk("stall", 64'(cpu_stall), 64'(m_stall));
        chk("readdata", 64'(cpu_readdata), 64'(model_read(we, re, a, rd)));
        chk("raddr", 64'(mem_raddr), 64'(a));

        prev_hold  = rst && (n != 0) && !wr;
        prev_waddr = mem_waddr;
        prev_wdata = mem_wdata;
        last_enq   = rst && m_enq;

        if (!rst) begin
            exp_q.delete();
        end else begin
            if (m_deq) begin
                drained.push_back(exp_q[0][63:32]);
                void'(exp_q.pop_front());
            end
            if (m_enq) exp_q.push_back({a, d});
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wready;
        logic [31:0] rdata;
        logic [31:0] e_rdata;
        logic        e_stall;
        logic        e_wvalid;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
        logic [2:0]  e_count;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic re, input logic [31:0] a,
                                input logic [31:0] d, input logic wr, input logic [31:0] rd,
                                input logic [31:0] er, input logic es, input logic ev,
                                input logic [31:0] ea, input logic [31:0] ed, input logic [2:0] ec);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d; v.wready = wr; v.rdata = rd;
        v.e_rdata = er; v.e_stall = es; v.e_wvalid = ev;
        v.e_waddr = ea; v.e_wdata = ed; v.e_count = ec;
        return v;
    endfunction

    // ---------------- test ----------------
    initial begin
        int i;
        int c;
        reset = 1'b0; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_wready = 1'b0; mem_rdata = '0;

        // basic store
        tbl.push_back(mk(1,0,32'h10,32'hDEADBEEF,1,32'h0,    32'h0,0,0,32'h0,32'h0,3'd0));
        tbl.push_back(mk(0,0,32'h0,32'h0,1,32'h1234,         32'h1234,0,1,32'h10,32'hDEADBEEF,3'd1));
        tbl.push_back(mk(0,0,32'h0,32'h0,0,32'h0,            32'h0,0,0,32'h0,32'h0,3'd0));
        // fill to full, fifth store stalls then goes in on the draining cycle
        tbl.push_back(mk(1,0,32'h0,32'hA0,0,32'h0,           32'h0,0,0,32'h0,32'h0,3'd0));
        tbl.push_back(mk(1,0,32'h4,32'hA1,0,32'h0,           32'h0,0,1,32'h0,32'hA0,3'd1));
        tbl.push_back(mk(1,0,32'h8,32'hA2,0,32'h0,           32'h0,0,1,32'h0,32'hA0,3'd2));
        tbl.push_back(mk(1,0,32'hC,32'hA3,0,32'h0,           32'h0,0,1,32'h0,32'hA0,3'd3));
        tbl.push_back(mk(1,0,32'h10,32'hA4,0,32'h0,          32'h0,1,1,32'h0,32'hA0,3'd4));
        tbl.push_back(mk(1,0,32'h10,32'hA4,1,32'h0,          32'h0,0,1,32'h0,32'hA0,3'd4));
        tbl.push_back(mk(0,0,32'h0,32'h0,1,32'h0,            32'h0,0,1,32'h4,32'hA1,3'd4));
        tbl.push_back(mk(0,0,32'h0,32'h0,1,32'h0,            32'h0,0,1,32'h8,32'hA2,3'd3));
        tbl.push_back(mk(0,0,32'h0,32'h0,1,32'h0,            32'h0,0,1,32'hC,32'hA3,3'd2));
        tbl.push_back(mk(0,0,32'h0,32'h0,1,32'h0,            32'h0,0,1,32'h10,32'hA4,3'd1));
        tbl.push_back(mk(0,0,32'h0,32'h0,0,32'h0,            32'h0,0,0,32'h0,32'h0,3'd0));
        // forwarding youngest / miss / load+store / draining-entry hit
        tbl.push_back(mk(1,0,32'h20,32'h11111111,0,32'h0,    32'h0,0,0,32'h0,32'h0,3'd0));
        tbl.push_back(mk(1,0,32'h20,32'h22222222,0,32'h0,    32'h0,0,1,32'h20,32'h11111111,3'd1));
        tbl.push_back(mk(0,1,32'h22,32'h0,0,32'h0BADF00D,    32'h22222222,0,1,32'h20,32'h11111111,3'd2));
        tbl.push_back(mk(0,1,32'h24,32'h0,0,32'h0BADF00D,    32'h0BADF00D,0,1,32'h20,32'h11111111,3'd2));
        tbl.push_back(mk(1,1,32'h28,32'h33,0,32'h55,         32'h0,0,1,32'h20,32'h11111111,3'd2));
        tbl.push_back(mk(0,1,32'h28,32'h0,0,32'h55,          32'h33,0,1,32'h20,32'h11111111,3'd3));
        tbl.push_back(mk(0,1,32'h20,32'h0,1,32'h55,          32'h22222222,0,1,32'h20,32'h11111111,3'd3));
        tbl.push_back(mk(0,1,32'h20,32'h0,1,32'h55,          32'h22222222,0,1,32'h20,32'h22222222,3'd2));
        tbl.push_back(mk(0,0,32'h0,32'h0,1,32'h66,           32'h66,0,1,32'h28,32'h33,3'd1));
        tbl.push_back(mk(0,1,32'h20,32'h0,1,32'h77,          32'h77,0,0,32'h0,32'h0,3'd0));

        @(posedge clk);
        #1;
        // reset and reset-state checks
        cycle(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        cycle(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("reset_count", 64'(s_count), 64'd0);
        chk("reset_empty", 64'(s_empty), 64'd1);
        chk("reset_wvalid", 64'(s_wvalid), 64'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(1, tbl[k].we, tbl[k].re, tbl[k].addr, tbl[k].wdata, tbl[k].wready, tbl[k].rdata);
            chk($sformatf("tbl%0d_rdata", k), 64'(s_rdata), 64'(tbl[k].e_rdata));
            chk($sformatf("tbl%0d_stall", k), 64'(s_stall), 64'(tbl[k].e_stall));
            chk($sformatf("tbl%0d_wvalid", k), 64'(s_wvalid), 64'(tbl[k].e_wvalid));
            chk($sformatf("tbl%0d_count", k), 64'(s_count), 64'(tbl[k].e_count));
            if (tbl[k].e_wvalid) begin
                chk($sformatf("tbl%0d_waddr", k), 64'(s_waddr), 64'(tbl[k].e_waddr));
                chk($sformatf("tbl%0d_wdata", k), 64'(s_wdata), 64'(tbl[k].e_wdata));
            end
        end

        // reset mid-drain: three stores held back, reset while a store and
        // mem_wready are both asserted, then nothing may appear on mem_w*
        cycle(1, 1, 0, 32'h100, 32'hB0, 0, 32'h0);
        cycle(1, 1, 0, 32'h104, 32'hB1, 0, 32'h0);
        cycle(1, 1, 0, 32'h108, 32'hB2, 0, 32'h0);
        chk("pre_reset_count", 64'(s_count), 64'd2);
        cycle(0, 1, 0, 32'h10C, 32'hB3, 1, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        chk("mid_reset_count", 64'(s_count), 64'd0);
        chk("mid_reset_empty", 64'(s_empty), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mid_reset_wvalid%0d", k), 64'(s_wvalid), 64'd0);
            cycle(1, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        end

        // wrap-around with alternating backpressure
        drained.delete();
        i = 0;
        c = 0;
        while (i < 10 && c < 200) begin
            cycle(1, 1, 0, 32'(4 * i), 32'(i), (c % 2) == 0, 32'h0);
            if (last_enq) i++;
            c++;
        end
        chk("wrap_accept_timeout", 64'(c < 200), 64'd1);
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            cycle(1, 0, 0, 32'h0, 32'h0, (c % 2) == 0, 32'h0);
            c++;
        end
        chk("wrap_drain_timeout", 64'(c < 100), 64'd1);
        chk("wrap_drain_len", 64'(drained.size()), 64'd10);
        for (int k = 0; k < 10 && k < drained.size(); k++) begin
            chk($sformatf("wrap_order%0d", k), 64'(drained[k]), 64'(4 * k));
        end

        // random traffic against the queue model
        for (int k = 0; k < 400; k++) begin
            logic        r_rst, r_we, r_re, r_wr;
            logic [31:0] r_a;
            r_rst = ($urandom_range(0, 63) != 0);
            r_we  = ($urandom_range(0, 2) != 0);
            r_re  = ($urandom_range(0, 1) == 1);
            r_wr  = ($urandom_range(0, 2) == 0);
            r_a   = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            cycle(r_rst, r_we, r_re, r_a, $urandom, r_wr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side buffer placed directly downstream of pipeLinedProcessor's memory-stage outputs (memwrite, aluout, writedata), in front of the data memory.
- Queues processor stores in a FIFO and drains them to memory through a valid/ready handshake.
- Forwards the youngest pending store's data to loads that hit in the buffer, so readdata is always coherent.
- The processor stalls only when the buffer is full.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. Asserted when 0 at the rising clk edge.
- cpu_memwrite  in  1  store request, from processor memwrite.
- cpu_memread  in  1  load request.
- cpu_addr  in  AW  byte address, from processor aluout.
- cpu_wdata  in  DW  store data, from processor writedata.
- cpu_readdata  out  DW  load data, to processor readdata.
- cpu_stall  out  1  store not accepted this cycle; processor must hold its request.
- mem_wvalid  out  1  head entry valid for memory write.
- mem_wready  in  1  memory accepts the head entry.
- mem_waddr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_raddr  out  AW  load address, equal to cpu_addr.
- mem_rdata  in  DW  combinational read data from memory.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- empty  out  1  count==0.

Behaviour:
- Reset (reset==0 at the clk edge):
  - head=0, tail=0, count=0, empty=1.
  - mem_wvalid=0; entries invalidated.
  - Stores pending at reset are discarded, including one mid-handshake.
  - reset has priority over all other inputs.
- Storage: circular FIFO of {addr, data}; head and tail pointers wrap modulo DEPTH.
- Dequeue condition: deq = mem_wvalid & mem_wready.
  - mem_wvalid = !empty.
  - mem_waddr and mem_wdata come from the head entry.
  - They stay stable while mem_wvalid=1 and mem_wready=0.
  - On deq, head advances at the clk edge.
- Enqueue condition: enq = cpu_memwrite & (count<DEPTH | deq).
  - On enq, {cpu_addr, cpu_wdata} are written at tail and tail advances.
- Stall: cpu_stall = cpu_memwrite & (count==DEPTH) & !deq.
  - Combinational, including the path from mem_wready.
- Count update:
  - count += 1 on enq only.
  - count -= 1 on deq only.
  - count is unchanged on simultaneous enq and deq, including at full (full stays full, no stall).
- Latency:
  - An accepted store is visible on mem_w* the cycle after acceptance at the earliest.
  - There is no bypass from cpu to mem_w* in the same cycle.
- Load forwarding (combinational):
  - When cpu_memread=1 and cpu_memwrite=0, compare cpu_addr[AW-1:2] against every valid entry.
  - If at least one entry matches, cpu_readdata = data of the youngest matching entry (closest to tail).
  - Otherwise cpu_readdata = mem_rdata.
  - An entry being dequeued in the current cycle still counts as valid for forwarding.
- Address bits [1:0] are ignored for matching; the buffer handles word accesses only.
- cpu_memread=0 gives cpu_readdata = mem_rdata.
- If cpu_memread and cpu_memwrite are both 1, the store is processed normally and cpu_readdata = 0.
- mem_raddr = cpu_addr at all times.
- No ordering is kept between memory writes and external memory reads. Forwarding alone guarantees processor coherence.

Test Plan:
- Reset mid-drain:
  - Stimulus: enqueue 3 stores with mem_wready=0, then drive reset=0 for one cycle.
  - Required: count=0, empty=1, mem_wvalid=0. With mem_wready then raised, no write appears on mem_w*.
- Basic store:
  - Stimulus: mem_wready=1, store addr 0x00000010 data 0xDEADBEEF.
  - Required: next cycle mem_wvalid=1, mem_waddr=0x10, mem_wdata=0xDEADBEEF. The cycle after, count=0.
- Fill to full:
  - Stimulus: mem_wready=0, stores to 0x0, 0x4, 0x8, 0xC, then a fifth to 0x10.
  - Required: count=4; cpu_stall=1 on the fifth store. Raising mem_wready accepts the fifth in the same cycle; count stays 4; drain order is 0x0, 0x4, 0x8, 0xC, 0x10.
- Forwarding youngest:
  - Stimulus: mem_wready=0, store 0x20←0x11111111, then 0x20←0x22222222. Load 0x22 (addr bits [1:0] ignored) with mem_rdata=0x0BADF00D.
  - Required: cpu_readdata=0x22222222.
- Forwarding miss:
  - Stimulus: same buffer state as the forwarding-youngest case, load 0x24 with mem_rdata=0x0BADF00D.
  - Required: cpu_readdata=0x0BADF00D.
- Wrap-around and backpressure:
  - Stimulus: 10 stores, addr=4*i, data=i, with mem_wready toggling 1,0,1,0…
  - Required: all 10 writes appear in order; mem_waddr and mem_wdata are stable whenever mem_wvalid=1 and mem_wready=0; count never exceeds 4.
